// File: rtl/cia_seq_pkg.sv
// Shared types and constants for the CIA bus sequencer: FSM state encoding,
// chip-select bit positions and default E clock timing.
package cia_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    CYCLE,
    ACK
  } state_e;

  localparam int SEL_A      = 0;
  localparam int SEL_B      = 1;
  localparam int E_DIV_DEF  = 10;
  localparam int E_HIGH_DEF = 4;

endpackage

// File: rtl/e_clock_gen.sv
// Free-running E clock generator: divides clk by E_DIV, E high for the last
// E_HIGH clocks of each period, plus a pulse marking the final clock.
module e_clock_gen #(
  parameter int E_DIV  = 10,
  parameter int E_HIGH = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic e,
  output logic e_last
);

  localparam int CW = (E_DIV > 1) ? $clog2(E_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(E_DIV - 1);
  localparam logic [CW-1:0] HIGH_START = CW'(E_DIV - E_HIGH);

  logic [CW-1:0] ecnt_q, ecnt_d;
  logic          e_q, e_d;

  // E is computed from the next count so the registered E always agrees
  // with the count value it is presented alongside.
  always_comb begin
    ecnt_d = (ecnt_q == CNT_LAST) ? '0 : ecnt_q + 1'b1;
    e_d    = (ecnt_d >= HIGH_START);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ecnt_q <= '0;
      e_q    <= 1'b0;
    end else begin
      ecnt_q <= ecnt_d;
      e_q    <= e_d;
    end
  end

  assign e      = e_q;
  assign e_last = (ecnt_q == CNT_LAST);

endmodule

// File: rtl/cia_bus_sequencer.sv
// Sequences 68000 bus cycles onto the two 8520 CIAs as E-synchronous accesses.
// Build option CIA_RDLATCH_EN: registered read data and _DTACK from ACK only.
module cia_bus_sequencer
  import cia_seq_pkg::*;
#(
  parameter int E_DIV  = E_DIV_DEF,
  parameter int E_HIGH = E_HIGH_DEF
) (
  input  logic       CLK,
  input  logic       _RES,
  output logic       E,
  input  logic       _AS,
  input  logic       R_W,
  input  logic [1:0] CIA_SEL,
  input  logic [3:0] RS_IN,
  input  logic [7:0] D_CPU_IN,
  output logic [7:0] D_CPU_OUT,
  output logic       _DTACK,
  output logic       _CS_A,
  output logic       _CS_B,
  output logic [3:0] RS,
  output logic       CIA_R_W,
  output logic [7:0] D_CIA_OUT,
  output logic       D_CIA_OE,
  input  logic [7:0] D_CIA_IN
);

  logic e_last;

  e_clock_gen #(
    .E_DIV (E_DIV),
    .E_HIGH(E_HIGH)
  ) u_e_clock_gen (
    .clk   (CLK),
    .rst_n (_RES),
    .e     (E),
    .e_last(e_last)
  );

  state_e     state_q, state_d;
  logic [3:0] rs_q, rs_d;
  logic       r_w_q, r_w_d;
  logic [1:0] sel_q, sel_d;
  logic [7:0] wdata_q, wdata_d;
  logic       as_rose_q, as_rose_d;
`ifdef CIA_RDLATCH_EN
  logic [7:0] rdata_q, rdata_d;
`endif

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    rs_d      = rs_q;
    r_w_d     = r_w_q;
    sel_d     = sel_q;
    wdata_d   = wdata_q;
    as_rose_d = as_rose_q;
`ifdef CIA_RDLATCH_EN
    rdata_d   = rdata_q;
`endif
    case (state_q)
      IDLE: begin
        as_rose_d = 1'b0;
        if (!_AS && (CIA_SEL != 2'b00)) begin
          rs_d    = RS_IN;
          r_w_d   = R_W;
          sel_d   = CIA_SEL;
          wdata_d = D_CPU_IN;
          state_d = SYNC;
        end
      end
      SYNC: begin
        if (_AS) state_d = IDLE;
        else if (e_last) state_d = CYCLE;
      end
      CYCLE: begin
        // Runs to completion even if the CPU walks away: CIA reads have side effects.
        if (_AS) as_rose_d = 1'b1;
        if (e_last) begin
`ifdef CIA_RDLATCH_EN
          rdata_d = D_CIA_IN;
`endif
          state_d = (as_rose_q || _AS) ? IDLE : ACK;
        end
      end
      ACK: begin
        if (_AS) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge _RES) begin
    if (!_RES) begin
      state_q   <= IDLE;
      rs_q      <= '0;
      r_w_q     <= 1'b1;
      sel_q     <= '0;
      wdata_q   <= '0;
      as_rose_q <= 1'b0;
`ifdef CIA_RDLATCH_EN
      rdata_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rs_q      <= rs_d;
      r_w_q     <= r_w_d;
      sel_q     <= sel_d;
      wdata_q   <= wdata_d;
      as_rose_q <= as_rose_d;
`ifdef CIA_RDLATCH_EN
      rdata_q   <= rdata_d;
`endif
    end
  end

  // Bus drive decodes straight from the state flop so an async reset drops
  // the chip selects and data enable in the same instant.
  logic in_cycle;

  always_comb begin
    in_cycle  = (state_q == CYCLE);
    _CS_A     = ~(in_cycle & sel_q[SEL_A]);
    _CS_B     = ~(in_cycle & sel_q[SEL_B]);
    RS        = in_cycle ? rs_q : 4'h0;
    CIA_R_W   = in_cycle ? r_w_q : 1'b1;
    D_CIA_OE  = in_cycle & ~r_w_q;
    D_CIA_OUT = in_cycle ? wdata_q : 8'h00;
`ifdef CIA_RDLATCH_EN
    _DTACK    = ~(state_q == ACK);
    D_CPU_OUT = rdata_q;
`else
    _DTACK    = ~((state_q == ACK) | (in_cycle & e_last & ~as_rose_q & ~_AS));
    D_CPU_OUT = D_CIA_IN;
`endif
  end

endmodule

// File: tb/tb_cia_bus_sequencer.sv
// Self-checking bench for cia_bus_sequencer: a period/window model of the E
// clock and CIA access timing, checked every cycle, plus directed scenarios.
module tb_cia_bus_sequencer;

  localparam int PER   = 10;
  localparam int HIGH  = 4;
`ifdef CIA_RDLATCH_EN
  localparam int LAT_ADJ = 0;
`else
  localparam int LAT_ADJ = -1;
`endif

  logic       CLK = 1'b0;
  logic       _RES = 1'b0;
  logic       E;
  logic       _AS = 1'b1;
  logic       R_W = 1'b1;
  logic [1:0] CIA_SEL = 2'b00;
  logic [3:0] RS_IN = 4'h0;
  logic [7:0] D_CPU_IN = 8'h00;
  logic [7:0] D_CPU_OUT;
  logic       _DTACK;
  logic       _CS_A;
  logic       _CS_B;
  logic [3:0] RS;
  logic       CIA_R_W;
  logic [7:0] D_CIA_OUT;
  logic       D_CIA_OE;
  logic [7:0] D_CIA_IN = 8'h00;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  cia_bus_sequencer dut (
    .CLK      (CLK),
    ._RES     (_RES),
    .E        (E),
    ._AS      (_AS),
    .R_W      (R_W),
    .CIA_SEL  (CIA_SEL),
    .RS_IN    (RS_IN),
    .D_CPU_IN (D_CPU_IN),
    .D_CPU_OUT(D_CPU_OUT),
    ._DTACK   (_DTACK),
    ._CS_A    (_CS_A),
    ._CS_B    (_CS_B),
    .RS       (RS),
    .CIA_R_W  (CIA_R_W),
    .D_CIA_OUT(D_CIA_OUT),
    .D_CIA_OE (D_CIA_OE),
    .D_CIA_IN (D_CIA_IN)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: n is the clock interval index since reset release, so the E phase
  // is n mod PER. An accepted request owns the window [cyc_lo, cyc_lo+PER-1],
  // where cyc_lo is the first period start at least two intervals later.
  int         n = 0;
  bit         busy = 1'b0;
  bit         in_ack = 1'b0;
  bit         as_rose = 1'b0;
  int         cyc_lo = 0;
  logic [1:0] m_sel = 2'b00;
  logic       m_rw = 1'b1;
  logic [3:0] m_rs = 4'h0;
  logic [7:0] m_wd = 8'h00;
  logic [7:0] m_rdata = 8'h00;

  always @(posedge CLK or negedge _RES) begin
    if (!_RES) begin
      n = 0; busy = 0; in_ack = 0; as_rose = 0; m_rdata = 8'h00;
    end else begin
      if (!busy) begin
        if (!_AS && CIA_SEL != 2'b00) begin
          busy = 1; as_rose = 0;
          m_sel = CIA_SEL; m_rw = R_W; m_rs = RS_IN; m_wd = D_CPU_IN;
          cyc_lo = ((n + 2 + PER - 1) / PER) * PER;
        end
      end else if (in_ack) begin
        if (_AS) begin busy = 0; in_ack = 0; end
      end else if (n < cyc_lo) begin
        if (_AS) busy = 0;
      end else begin
        if (_AS) as_rose = 1;
        if (n == cyc_lo + PER - 1) begin
          m_rdata = D_CIA_IN;
          if (as_rose) busy = 0;
          else in_ack = 1;
        end
      end
      n++;
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      bit   in_cyc;
      logic exp_dtack;
      in_cyc = busy && !in_ack && (n >= cyc_lo);
`ifdef CIA_RDLATCH_EN
      exp_dtack = !in_ack;
`else
      exp_dtack = !(in_ack || (in_cyc && n == cyc_lo + PER - 1 && !as_rose && !_AS));
`endif
      check("e_clock",   32'(E),        32'((n % PER) >= (PER - HIGH)));
      check("cs_a",      32'(_CS_A),    32'(!(in_cyc && m_sel[0])));
      check("cs_b",      32'(_CS_B),    32'(!(in_cyc && m_sel[1])));
      check("rs",        32'(RS),       32'(in_cyc ? m_rs : 4'h0));
      check("cia_r_w",   32'(CIA_R_W),  32'(in_cyc ? m_rw : 1'b1));
      check("d_cia_oe",  32'(D_CIA_OE), 32'(in_cyc && !m_rw));
      check("d_cia_out", 32'(D_CIA_OUT), 32'(in_cyc ? m_wd : 8'h00));
      check("dtack",     32'(_DTACK),   32'(exp_dtack));
`ifdef CIA_RDLATCH_EN
      check("d_cpu_out", 32'(D_CPU_OUT), 32'(m_rdata));
`else
      check("d_cpu_out", 32'(D_CPU_OUT), 32'(D_CIA_IN));
`endif
    end
  end

  task automatic wait_phase(input int k);
    @(posedge CLK); #1;
    while ((n % PER) != k) begin
      @(posedge CLK); #1;
    end
  endtask

  // Issues one access sampled at phase k. rel >= 0 releases _AS that many
  // intervals after the sample; rel < 0 holds it until two clocks into _DTACK.
  task automatic run_access(input logic [1:0] sel, input logic rw, input logic [3:0] rs,
                            input logic [7:0] wd, input int k, input int rel,
                            output int lat, output int csa, output int csb,
                            output int oe, output logic [7:0] rd);
    int n_s;
    wait_phase(k);
    n_s = n;
    _AS = 1'b0; R_W = rw; CIA_SEL = sel; RS_IN = rs; D_CPU_IN = wd;
    lat = -1; csa = 0; csb = 0; oe = 0; rd = 8'h00;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (!_CS_A) csa++;
      if (!_CS_B) csb++;
      if (D_CIA_OE) oe++;
      if (!_DTACK && lat < 0) begin
        lat = n - n_s;
        rd  = D_CPU_OUT;
      end
      @(posedge CLK); #1;
      if ((rel >= 0 && (n - n_s) == rel) || (rel < 0 && lat >= 0 && (n - n_s) == lat + 2)) begin
        _AS = 1'b1; CIA_SEL = 2'b00;
      end
    end
    _AS = 1'b1; CIA_SEL = 2'b00;
  endtask

  initial begin
    int lat, csa, csb, oe, hi_cnt, first_hi;
    logic [7:0] rd;

    #1 cmp_en = 1'b1;
    #21 _RES = 1'b1;

    // Idle: E high 4 of every 10 clocks, first rise at phase 6.
    hi_cnt = 0; first_hi = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (E) hi_cnt++;
      if (E && first_hi < 0) first_hi = i;
    end
    check("t1_e_high_cnt", 32'(hi_cnt), 32'd12);
    check("t1_e_first_high", 32'(first_hi), 32'd5);

    // Read CIA-A at phase 8: best-case latency.
    D_CIA_IN = 8'h82;
    run_access(2'b01, 1'b1, 4'hD, 8'h00, 8, -1, lat, csa, csb, oe, rd);
    check("t2_latency", 32'(lat), 32'(12 + LAT_ADJ));
    check("t2_cs_a_len", 32'(csa), 32'd10);
    check("t2_cs_b_len", 32'(csb), 32'd0);
    check("t2_read_data", 32'(rd), 32'h82);

    // Write CIA-B at phase 9: waits one extra E period.
    D_CIA_IN = 8'h11;
    run_access(2'b10, 1'b0, 4'h1, 8'h5A, 9, -1, lat, csa, csb, oe, rd);
    check("t3_latency", 32'(lat), 32'(21 + LAT_ADJ));
    check("t3_cs_b_len", 32'(csb), 32'd10);
    check("t3_cs_a_len", 32'(csa), 32'd0);
    check("t3_oe_len", 32'(oe), 32'd10);

    // Abort while waiting for the period boundary.
    run_access(2'b01, 1'b1, 4'h4, 8'h00, 2, 3, lat, csa, csb, oe, rd);
    check("t4a_cs_a_len", 32'(csa), 32'd0);
    check("t4a_no_dtack", 32'(lat), 32'hFFFF_FFFF);

    // Abort mid-cycle: chip select still runs the full period.
    run_access(2'b01, 1'b1, 4'h4, 8'h00, 8, 5, lat, csa, csb, oe, rd);
    check("t4b_cs_a_len", 32'(csa), 32'd10);
    check("t4b_no_dtack", 32'(lat), 32'hFFFF_FFFF);

    // Write to both CIAs at once.
    run_access(2'b11, 1'b0, 4'h3, 8'hC3, 5, -1, lat, csa, csb, oe, rd);
    check("t5_latency", 32'(lat), 32'(15 + LAT_ADJ));
    check("t5_cs_a_len", 32'(csa), 32'd10);
    check("t5_cs_b_len", 32'(csb), 32'd10);
    check("t5_oe_len", 32'(oe), 32'd10);

    // Async reset at phase 5 of a write cycle.
    wait_phase(8);
    _AS = 1'b0; R_W = 1'b0; CIA_SEL = 2'b01; RS_IN = 4'h2; D_CPU_IN = 8'hA5;
    repeat (7) @(posedge CLK);
    #1;
    check("t6_phase", 32'(n % PER), 32'd5);
    check("t6_cs_a_before", 32'(_CS_A), 32'd0);
    check("t6_oe_before", 32'(D_CIA_OE), 32'd1);
    #2 _RES = 1'b0;
    #1;
    check("t6_cs_a_after", 32'(_CS_A), 32'd1);
    check("t6_oe_after", 32'(D_CIA_OE), 32'd0);
    check("t6_e_after", 32'(E), 32'd0);
    check("t6_dtack_after", 32'(_DTACK), 32'd1);
    _AS = 1'b1; CIA_SEL = 2'b00;
    repeat (3) @(negedge CLK);
    #2 _RES = 1'b1;

    // Normal access after reset recovery.
    D_CIA_IN = 8'h3C;
    run_access(2'b10, 1'b1, 4'hE, 8'h00, 0, -1, lat, csa, csb, oe, rd);
    check("t7_latency", 32'(lat), 32'(20 + LAT_ADJ));
    check("t7_cs_b_len", 32'(csb), 32'd10);
    check("t7_read_data", 32'(rd), 32'h3C);

    repeat (5) @(negedge CLK);
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
